// File: rtl/button_encoder.sv
// Four-button front end: two-flop synchroniser, debounce FSM with chord lockout,
// and a 2-bit colour encoder that emits one KEY_VALID pulse per accepted press.
module button_encoder #(
  parameter int DB_CYCLES = 200000,
  parameter int CNT_W     = 18
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       EN,
  output logic [1:0] KEY,
  output logic       KEY_VALID,
  output logic       PRESSED
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       s1_q, s2_q;
  logic [3:0]       cap_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       key_q;
  logic             kv_q;
  logic             pressed_q;
  state_t           state_q;

  logic is_zero, is_onehot, is_multi, cnt_last;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= BTN;
      s2_q <= s1_q;
    end
  end

  // A nonzero value with no bit left after clearing its lowest set bit is one-hot.
  assign is_zero   = (s2_q == 4'b0000);
  assign is_onehot = !is_zero && ((s2_q & (s2_q - 4'd1)) == 4'b0000);
  assign is_multi  = !is_zero && !is_onehot;
  assign cnt_last  = (cnt_q == CNT_LAST);

  function automatic logic [1:0] encode(input logic [3:0] onehot);
    if (onehot[3])      return 2'd3;
    else if (onehot[2]) return 2'd2;
    else if (onehot[1]) return 2'd1;
    else                return 2'd0;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_q     <= 4'b0000;
      key_q     <= 2'd0;
      kv_q      <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      kv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_onehot) begin
            state_q <= DB_PRESS;
            cap_q   <= s2_q;
            cnt_q   <= '0;
          end else if (is_multi) begin
            state_q <= WAIT_REL;
            cnt_q   <= '0;
          end
        end
        DB_PRESS: begin
          if (s2_q == cap_q) begin
            if (cnt_last) begin
              state_q   <= HELD;
              key_q     <= encode(cap_q);
              kv_q      <= EN;
              pressed_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else if (is_zero) begin
            state_q <= IDLE;
          end else if (is_onehot) begin
            cap_q <= s2_q;
            cnt_q <= '0;
          end else begin
            state_q <= WAIT_REL;
            cnt_q   <= '0;
          end
        end
        HELD: begin
          // Any change while held (release or an extra button) goes through lockout.
          if (s2_q != cap_q) begin
            state_q   <= WAIT_REL;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
          end
        end
        WAIT_REL: begin
          if (!is_zero) begin
            cnt_q <= '0;
          end else if (cnt_last) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign KEY       = key_q;
  assign KEY_VALID = kv_q;
  assign PRESSED   = pressed_q;

endmodule

// File: tb/tb_button_encoder.sv
// Scoreboard bench for button_encoder with DB_CYCLES=4: expected pulses are queued
// as stimulus is driven and matched (key and edge number) when KEY_VALID fires.
module tb_button_encoder;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BTN;
  logic       EN;
  logic [1:0] KEY;
  logic       KEY_VALID;
  logic       PRESSED;

  typedef struct {
    logic [1:0] key;
    int         at_edge;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;
  logic kv_prev = 1'b0;

  button_encoder #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN(BTN), .EN(EN),
    .KEY(KEY), .KEY_VALID(KEY_VALID), .PRESSED(PRESSED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_n <= edge_n + 1;

  // Pulse monitor: every KEY_VALID must match the oldest queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (KEY_VALID) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got KEY=%0d at edge %0d, required no pulse", KEY, edge_n);
      end else begin
        e = sb.pop_front();
        if (KEY !== e.key || edge_n != e.at_edge) begin
          errors++;
          $display("FAIL pulse: got KEY=%0d at edge %0d, required KEY=%0d at edge %0d",
                   KEY, edge_n, e.key, e.at_edge);
        end else begin
          $display("pulse ok: KEY=%0d at edge %0d", KEY, edge_n);
        end
      end
      checks++;
      if (kv_prev) begin
        errors++;
        $display("FAIL pulse_width: KEY_VALID high two cycles in a row at edge %0d, required single cycle", edge_n);
      end
    end
    kv_prev = KEY_VALID;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    BTN = v;
    tick(n);
  endtask

  task automatic expect_pulse(input logic [1:0] k);
    exp_t e;
    e.key     = k;
    e.at_edge = edge_n + LAT;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if (KEY !== 2'd0 || KEY_VALID !== 1'b0 || PRESSED !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got KEY=%0d KV=%b PRESSED=%b, required 0 0 0", KEY, KEY_VALID, PRESSED);
    end
    RST_N = 1'b1;
    tick(3);
    checks++;
    if (KEY !== 2'd0 || PRESSED !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got KEY=%0d PRESSED=%b, required 0 0", KEY, PRESSED);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press;
    expect_pulse(2'd2);
    drive(4'b0100, 20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL clean_pulse_seen: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (PRESSED !== 1'b1 || KEY !== 2'd2) begin
      errors++;
      $display("FAIL clean_held: got PRESSED=%b KEY=%0d, required 1 2", PRESSED, KEY);
    end
    drive(4'b0000, 10);
    checks++;
    if (PRESSED !== 1'b0 || KEY !== 2'd2) begin
      errors++;
      $display("FAIL clean_release: got PRESSED=%b KEY=%0d, required 0 2", PRESSED, KEY);
    end
    $display("test_clean_press done");
  endtask

  task automatic test_bounce;
    drive(4'b0010, 1);
    drive(4'b0000, 1);
    drive(4'b0010, 1);
    drive(4'b0000, 1);
    expect_pulse(2'd1);
    drive(4'b0010, 15);
    drive(4'b0000, 1);
    drive(4'b0010, 1);
    drive(4'b0000, 12);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bounce_pulse_seen: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (PRESSED !== 1'b0 || KEY !== 2'd1) begin
      errors++;
      $display("FAIL bounce_release: got PRESSED=%b KEY=%0d, required 0 1", PRESSED, KEY);
    end
    $display("test_bounce done");
  endtask

  task automatic test_chord;
    drive(4'b0011, 5);
    drive(4'b0001, 10);
    checks++;
    if (PRESSED !== 1'b0 || KEY !== 2'd1) begin
      errors++;
      $display("FAIL chord_lockout: got PRESSED=%b KEY=%0d, required 0 1", PRESSED, KEY);
    end
    drive(4'b0000, 10);
    expect_pulse(2'd3);
    drive(4'b1000, 12);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL chord_recover: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    drive(4'b0000, 10);
    $display("test_chord done");
  endtask

  task automatic test_second_button;
    expect_pulse(2'd0);
    drive(4'b0001, 10);
    drive(4'b0101, 5);
    drive(4'b0100, 10);
    checks++;
    if (sb.size() != 0 || PRESSED !== 1'b0 || KEY !== 2'd0) begin
      errors++;
      $display("FAIL second_button_locked: got pending=%0d PRESSED=%b KEY=%0d, required 0 0 0",
               sb.size(), PRESSED, KEY);
      sb.delete();
    end
    drive(4'b0000, 10);
    expect_pulse(2'd2);
    drive(4'b0100, 10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL second_button_repress: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    drive(4'b0000, 10);
    $display("test_second_button done");
  endtask

  task automatic test_enable;
    EN = 1'b0;
    drive(4'b0010, 12);
    checks++;
    if (KEY !== 2'd1 || PRESSED !== 1'b1) begin
      errors++;
      $display("FAIL enable_off_tracking: got KEY=%0d PRESSED=%b, required 1 1", KEY, PRESSED);
    end
    drive(4'b0000, 10);
    EN = 1'b1;
    expect_pulse(2'd3);
    drive(4'b1000, 12);
    checks++;
    if (sb.size() != 0 || KEY !== 2'd3) begin
      errors++;
      $display("FAIL enable_on_pulse: got pending=%0d KEY=%0d, required 0 3", sb.size(), KEY);
      sb.delete();
    end
    drive(4'b0000, 10);
    $display("test_enable done");
  endtask

  task automatic test_reset_mid;
    drive(4'b0100, 5);
    RST_N = 1'b0;
    #1;
    checks++;
    if (KEY !== 2'd0 || KEY_VALID !== 1'b0 || PRESSED !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got KEY=%0d KV=%b PRESSED=%b, required 0 0 0", KEY, KEY_VALID, PRESSED);
    end
    tick(2);
    RST_N = 1'b1;
    expect_pulse(2'd2);
    tick(12);
    checks++;
    if (sb.size() != 0 || KEY !== 2'd2 || PRESSED !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_repress: got pending=%0d KEY=%0d PRESSED=%b, required 0 2 1",
               sb.size(), KEY, PRESSED);
      sb.delete();
    end
    drive(4'b0000, 10);
    $display("test_reset_mid done");
  endtask

  initial begin
    RST_N = 1'b0;
    BTN   = 4'b0000;
    EN    = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_second_button();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
